// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared states and constants for the instruction memory loader
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int IMEM_ADDR_W    = 7;
  localparam int MAX_WORDS      = 2 ** IMEM_ADDR_W;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - host byte stream handshake into the loader
interface imem_loader_if #(
  parameter int BYTE_W = 8
);
  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/imem_loader_byte_assembler.sv
// rtl/imem_loader_byte_assembler.sv - big-endian byte-to-word shift register with word_valid pulse
module byte_assembler
  import loader_pkg::*;
#(
  parameter int BYTE_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              shift,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [1:0]        byte_cnt,
  output logic              word_valid,
  output logic [DATA_W-1:0] word
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      byte_cnt   <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else if (clr) begin
      byte_cnt   <= '0;
      word_valid <= 1'b0;
    end else begin
      // Pulse lands one cycle after the 4th byte, while the word is still intact
      word_valid <= shift && (byte_cnt == LAST_BYTE);
      if (shift) begin
        word     <= {word[DATA_W-BYTE_W-1:0], byte_in};
        byte_cnt <= byte_cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams a program into instruction memory while holding the CPU in reset
// Optional trailing XOR checksum check enabled by IMEM_LOADER_CSUM_EN.
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  imem_loader_if.slave      in_if,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam int WCNT_W = ADDR_W + 1;
  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  state_t            state, next_state;
  logic [WCNT_W-1:0] word_cnt, n_words;
  logic              ready_q;
  logic              accept, data_acc, clr, last_word, last_byte, len_bad;
  logic [1:0]        byte_cnt;
  logic              word_valid;
  logic [DATA_W-1:0] word;

  assign in_if.in_ready = ready_q;
  assign accept    = in_if.in_valid && ready_q;
  assign data_acc  = accept && (state == DATA);
  assign clr       = start && (state inside {IDLE, DONE, ERR});
  assign last_word = (word_cnt == n_words - WCNT_W'(1));
  // Drop ready for the write cycle of the final word so no stray byte enters DATA
  assign last_byte = data_acc && (byte_cnt == LAST_BYTE) && last_word;
  assign len_bad   = (in_if.in_data == '0) || (int'(in_if.in_data) > (1 << ADDR_W));

  assign imem_we    = word_valid;
  assign imem_waddr = word_cnt[ADDR_W-1:0];
  assign imem_wdata = word;

  byte_assembler #(.BYTE_W(BYTE_W), .DATA_W(DATA_W)) u_asm (
    .clk        (clk),
    .reset      (reset),
    .clr        (clr),
    .shift      (data_acc),
    .byte_in    (in_if.in_data),
    .byte_cnt   (byte_cnt),
    .word_valid (word_valid),
    .word       (word)
  );

`ifdef IMEM_LOADER_CSUM_EN
  logic [BYTE_W-1:0] csum;

  always_ff @(posedge clk) begin
    if (!reset)        csum <= '0;
    else if (clr)      csum <= '0;
    else if (data_acc) csum <= csum ^ in_if.in_data;
  end
`endif

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (start) next_state = LEN;
      LEN:       if (accept) next_state = len_bad ? ERR : DATA;
      DATA: begin
        if (word_valid && last_word) begin
`ifdef IMEM_LOADER_CSUM_EN
          next_state = CSUM;
`else
          next_state = DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CSUM_EN
      CSUM:      if (accept) next_state = (in_if.in_data == csum) ? DONE : ERR;
`endif
      DONE, ERR: if (start) next_state = LEN;
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      ready_q  <= 1'b0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      word_cnt <= '0;
      n_words  <= '0;
    end else begin
      state    <= next_state;
      ready_q  <= (next_state inside {LEN, DATA, CSUM}) && !last_byte;
      cpu_hold <= next_state inside {LEN, DATA, CSUM, ERR};
      done     <= (next_state == DONE);
      err      <= (next_state == ERR);
      if (clr)             word_cnt <= '0;
      else if (word_valid) word_cnt <= word_cnt + WCNT_W'(1);
      if (state == LEN && accept) n_words <= WCNT_W'(in_if.in_data);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader (honours IMEM_LOADER_CSUM_EN)
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        imem_we;
  logic [6:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        cpu_hold, done, err;

  always #5 clk = ~clk;

  imem_loader_if #(.BYTE_W(8)) bus ();

  imem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_if      (bus),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Write monitor
  logic [38:0] wr_q[$];
  int          wr_cyc[$];
  logic        done_q = 1'b0;
  logic        hold_at_done = 1'b1;
  int          done_rises = 0;

  always @(negedge clk) begin
    cyc++;
    if (imem_we) begin
      wr_q.push_back({imem_waddr, imem_wdata});
      wr_cyc.push_back(cyc);
    end
    if (done && !done_q) begin
      hold_at_done = cpu_hold;
      done_rises++;
    end
    done_q = done;
  end

  // Reference model: expected writes and outcome from the stream rules
  logic [38:0] exp_q[$];
  bit          exp_done, exp_err, exp_bad_len;

  task automatic model(input int n, input logic [31:0] words[$], input int csum_byte);
    logic [7:0] x;
    exp_q.delete();
    x = 8'h00;
    exp_bad_len = (n == 0) || (n > 128);
    if (exp_bad_len) begin
      exp_done = 1'b0;
      exp_err  = 1'b1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({7'(i), words[i]});
      x = x ^ words[i][31:24] ^ words[i][23:16] ^ words[i][15:8] ^ words[i][7:0];
    end
`ifdef IMEM_LOADER_CSUM_EN
    exp_done = (8'(csum_byte) == x);
`else
    exp_done = 1'b1;
`endif
    exp_err = !exp_done;
  endtask

  // Drives bytes (starting at a negedge); stops early if the loader finishes or stalls
  task automatic send(input logic [7:0] s[$], input int gap_pct);
    int waited;
    for (int i = 0; i < s.size(); i++) begin
      if ($urandom_range(99) < gap_pct) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(3, 1)) @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = s[i];
      waited = 0;
      while (!bus.in_ready && !done && !err && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      if (!bus.in_ready) begin
        if (waited >= 200) check("send_timeout", 1, 0);
        break;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic build_stream(input int n, input logic [31:0] words[$], input int csum_byte,
                              output logic [7:0] s[$]);
    s.delete();
    s.push_back(8'(n));
    foreach (words[i]) begin
      s.push_back(words[i][31:24]);
      s.push_back(words[i][23:16]);
      s.push_back(words[i][15:8]);
      s.push_back(words[i][7:0]);
    end
    s.push_back(8'(csum_byte));
  endtask

  function automatic int xor_of(input logic [31:0] words[$]);
    logic [7:0] x = 8'h00;
    foreach (words[i]) x = x ^ words[i][31:24] ^ words[i][23:16] ^ words[i][15:8] ^ words[i][7:0];
    return int'(x);
  endfunction

  task automatic run_load(input string tag, input int n, input logic [31:0] words[$],
                          input int csum_byte, input int gap_pct);
    logic [7:0] s[$];
    int waited;
    wr_q.delete();
    wr_cyc.delete();
    done_rises = 0;
    model(n, words, csum_byte);
    build_stream(n, words, csum_byte, s);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send(s, gap_pct);
    if (exp_bad_len) check({tag, "_err_next_cycle"}, err, 1);
    waited = 0;
    while (!done && !err && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    repeat (5) @(negedge clk);
    check({tag, "_done"}, done, exp_done);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_cpu_hold"}, cpu_hold, exp_err);
    check({tag, "_nwrites"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), wr_q[i], exp_q[i]);
    if (exp_done) begin
      check({tag, "_hold_falls_with_done"}, hold_at_done, 0);
      check({tag, "_done_rises"}, done_rises, 1);
    end
  endtask

  initial begin
    logic [31:0] w[$];
    logic [7:0]  s[$];
    int n;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    check("rst_in_ready", bus.in_ready, 0);
    check("rst_we", imem_we, 0);
    check("rst_waddr", imem_waddr, 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_cpu_hold", cpu_hold, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);

    w = '{32'h20080005, 32'hAC080004};
    run_load("n2", 2, w, xor_of(w), 0);

    w.delete();
    run_load("n0", 0, w, 0, 0);
    run_load("n129", 129, w, 0, 0);

    w = '{32'h00000001};
    run_load("bad_csum", 1, w, 0, 0);

    w.delete();
    for (int i = 0; i < 128; i++) w.push_back($urandom);
    run_load("n128", 128, w, xor_of(w), 0);
    if (wr_cyc.size() == 128) check("n128_throughput", wr_cyc[127] - wr_cyc[0], 4 * 127);

    w = '{$urandom, $urandom, $urandom};
    run_load("n3_solid", 3, w, xor_of(w), 0);
    run_load("n3_gappy", 3, w, xor_of(w), 60);

    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(8, 1);
      w.delete();
      for (int i = 0; i < n; i++) w.push_back($urandom);
      run_load($sformatf("rand%0d", k), n, w, xor_of(w), 40);
    end

    // Reset in the middle of the second word, then a fresh load
    w = '{$urandom, $urandom, $urandom};
    build_stream(3, w, xor_of(w), s);
    s = s[0:6];
    wr_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send(s, 0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_cpu_hold", cpu_hold, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    check("midrst_done", done, 0);
    check("midrst_err", err, 0);
    check("midrst_partial_writes", wr_q.size(), 1);
    w = '{$urandom, $urandom};
    run_load("after_rst", 2, w, xor_of(w), 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
